unidad_riesgos: RTL and testbench
=================================

# unidad_riesgos

Pipeline hazard controller for the 5-stage core (IF, DEC, EXE, MEM, WB). It sits beside the forwarding unit and resolves the hazards forwarding cannot cover. Load-use dependencies get a one-cycle stall plus a bubble. Taken branches resolved in EXE cause a flush of IF/DEC. Multi-cycle data-memory accesses freeze the whole pipeline, with a watchdog. It also keeps saturating stall/flush statistics for performance measurement.

## Interface
Parameters:
- ADDR_W, 32, width of register identifiers (matches forwarding-unit operand/destination width)
- CNT_W, 16, width of statistics counters
- MEM_TIMEOUT, 64, MEM_WAIT cycles before mem_timeout asserts (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- src1_DEC, src2_DEC  in  ADDR_W  source registers of the instruction in DEC
- src_used_DEC  in  2  bit0: src1 read, bit1: src2 read
- dest_EXE  in  ADDR_W  destination of the instruction in EXE
- MEM_R_EN_EXE  in  1  instruction in EXE is a load
- branch_taken_EXE  in  1  taken branch resolved in EXE
- MEM_access_MEM  in  1  load/store occupying MEM
- mem_ready  in  1  data memory completes the access this cycle
- clear_stats  in  1  synchronous clear of both counters
- stall_PC, stall_DEC  out  1  hold PC and the IF/DEC register
- bubble_EXE  out  1  load NOP into the DEC/EXE register
- flush_IF, flush_DEC  out  1  squash the instructions in IF and DEC
- freeze_all  out  1  hold every pipeline register and the PC
- mem_timeout  out  1  sticky watchdog flag
- stall_cycles, flush_count  out  CNT_W  statistics
- state_dbg  out  1  0 = RUN, 1 = MEM_WAIT

## Operation
- Conditions, evaluated every cycle:
  - mw = MEM_access_MEM & ~mem_ready
  - lu = MEM_R_EN_EXE & ((src_used_DEC[0] & src1_DEC==dest_EXE) | (src_used_DEC[1] & src2_DEC==dest_EXE))
- Priority (exactly one action per cycle):
  - mw: freeze_all=1, all other control outputs 0
  - else branch_taken_EXE: flush_IF=flush_DEC=1; the DEC instruction is wrong-path, so lu is ignored
  - else lu: stall_PC=stall_DEC=bubble_EXE=1
  - else all outputs 0
- Register 0 is not special; a match on it still stalls.
- FSM with wait counter wcnt:
  - RUN: if mw → MEM_WAIT, wcnt←1.
  - MEM_WAIT: if ~mw → RUN, wcnt←0; else wcnt←wcnt+1, saturating at MEM_TIMEOUT.
  - When wcnt reaches MEM_TIMEOUT, mem_timeout←1. It clears only on rst. freeze_all stays asserted while mw holds.
- Counters saturate at all-ones, never wrap.
  - stall_cycles increments on every cycle with freeze_all or stall_PC.
  - flush_count increments on every cycle with flush_IF.
  - clear_stats zeroes both counters and takes precedence over increment in the same cycle.

## Timing
- Control outputs (stall_PC, stall_DEC, bubble_EXE, flush_IF, flush_DEC, freeze_all) are combinational from the inputs, with zero latency. They are forced to 0 while rst=1.
- state_dbg, mem_timeout, stall_cycles, flush_count and wcnt are registered. All reset to 0 and RUN.
- A load-use stall lasts exactly 1 cycle. Next cycle the load sits in MEM and forwarding covers it.
- Branch during a memory freeze: branch_taken_EXE is held by the frozen EXE register. The flush fires on the first cycle with mem_ready=1, together with the release of freeze_all.
- mem_ready=1 in the same cycle as MEM_access_MEM rises: no freeze, and the FSM stays in RUN.
- mem_timeout rises on the clock edge at the end of the MEM_TIMEOUT-th consecutive mw cycle.
- rst asserted mid-MEM_WAIT returns to RUN immediately; the counters and flag clear.

## Structure
- Package riesgos_pkg holds:
  - the FSM state enum (RUN, MEM_WAIT)
  - the CNT_W default
  - localparams for the src_used_DEC bit indices
- Sub-module contador_saturado (parameter W; ports clk, rst, clr, inc, q), instantiated twice for the statistics.

## Test plan
- Load-use: load to r5 in EXE, src1_DEC=5, src_used_DEC=2'b01 → stall_PC, stall_DEC, bubble_EXE high for 1 cycle; stall_cycles=1.
- Unused source: same stimulus with src_used_DEC=2'b10 and src2_DEC=7 → no stall.
- Branch vs load-use: branch_taken_EXE=1 together with a load-use match → flush_IF/flush_DEC=1, bubble_EXE=0; flush_count=1.
- Memory wait: MEM_access_MEM=1, mem_ready low for 3 cycles then high → freeze_all high for 3 cycles; state_dbg 1 for cycles 2–4; stall_cycles=3.
- Watchdog: MEM_TIMEOUT=4, mem_ready held low 6 cycles → mem_timeout rises after cycle 4 and stays high after release; rst clears it.
- Saturation/clear: CNT_W=2 with 5 stall cycles → stall_cycles=3. clear_stats asserted together with a stall → counter reads 0.

Source files
------------

// File: rtl/riesgos_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package riesgos_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } estado_e;

    localparam int unsigned CNT_W_DEF = 16;

    // Bit positions inside src_used_DEC.
    localparam int unsigned SRC1_BIT = 0;
    localparam int unsigned SRC2_BIT = 1;

endpackage

// File: rtl/contador_saturado.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module contador_saturado #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/unidad_riesgos.sv
// Hazard controller: load-use stall, branch flush, memory-wait freeze with
// watchdog, plus saturating stall/flush statistics.
module unidad_riesgos
    import riesgos_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src1_DEC,
    input  logic [ADDR_W-1:0] src2_DEC,
    input  logic [1:0]        src_used_DEC,
    input  logic [ADDR_W-1:0] dest_EXE,
    input  logic              MEM_R_EN_EXE,
    input  logic              branch_taken_EXE,
    input  logic              MEM_access_MEM,
    input  logic              mem_ready,
    input  logic              clear_stats,
    output logic              stall_PC,
    output logic              stall_DEC,
    output logic              bubble_EXE,
    output logic              flush_IF,
    output logic              flush_DEC,
    output logic              freeze_all,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count,
    output logic              state_dbg
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    logic mw;
    logic lu;

    estado_e           state_d, state_q;
    logic [WCNT_W-1:0] wcnt_d, wcnt_q;
    logic              timeout_d, timeout_q;

    assign mw = MEM_access_MEM & ~mem_ready;
    assign lu = MEM_R_EN_EXE &
                ((src_used_DEC[SRC1_BIT] & (src1_DEC == dest_EXE)) |
                 (src_used_DEC[SRC2_BIT] & (src2_DEC == dest_EXE)));

    // One action per cycle; a taken branch squashes DEC, so its load-use is moot.
    always_comb begin
        freeze_all = 1'b0;
        flush_IF   = 1'b0;
        flush_DEC  = 1'b0;
        stall_PC   = 1'b0;
        stall_DEC  = 1'b0;
        bubble_EXE = 1'b0;
        if (!rst) begin
            if (mw) begin
                freeze_all = 1'b1;
            end else if (branch_taken_EXE) begin
                flush_IF  = 1'b1;
                flush_DEC = 1'b1;
            end else if (lu) begin
                stall_PC   = 1'b1;
                stall_DEC  = 1'b1;
                bubble_EXE = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            RUN: begin
                if (mw) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mw) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q != WCNT_MAX) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
        // Flag rises on the edge that closes the MEM_TIMEOUT-th waiting cycle.
        if (mw && (wcnt_d == WCNT_MAX)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign state_dbg   = (state_q == MEM_WAIT);
    assign mem_timeout = timeout_q;

    contador_saturado #(
        .W (CNT_W)
    ) u_cnt_stall (
        .clk (clk),
        .rst (rst),
        .clr (clear_stats),
        .inc (freeze_all | stall_PC),
        .q   (stall_cycles)
    );

    contador_saturado #(
        .W (CNT_W)
    ) u_cnt_flush (
        .clk (clk),
        .rst (rst),
        .clr (clear_stats),
        .inc (flush_IF),
        .q   (flush_count)
    );

endmodule

// File: tb/tb_unidad_riesgos.sv
// Scoreboard bench for unidad_riesgos: a main instance plus a 2-bit-counter instance.
module tb_unidad_riesgos;

    localparam int unsigned AW = 5;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] src1, src2, dest;
    logic [1:0]    used;
    logic          ld, br, macc, rdy, clr;

    logic       stall_pc, stall_dec, bubble, flush_if, flush_dec, freeze, tmo, st;
    logic [7:0] sc, fc;
    logic       s_stall_pc, s_stall_dec, s_bubble, s_flush_if, s_flush_dec, s_freeze;
    logic       s_tmo, s_st;
    logic [1:0] sc2, fc2;

    always #5 clk = ~clk;

    unidad_riesgos #(
        .ADDR_W      (AW),
        .CNT_W       (8),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .src1_DEC         (src1),
        .src2_DEC         (src2),
        .src_used_DEC     (used),
        .dest_EXE         (dest),
        .MEM_R_EN_EXE     (ld),
        .branch_taken_EXE (br),
        .MEM_access_MEM   (macc),
        .mem_ready        (rdy),
        .clear_stats      (clr),
        .stall_PC         (stall_pc),
        .stall_DEC        (stall_dec),
        .bubble_EXE       (bubble),
        .flush_IF         (flush_if),
        .flush_DEC        (flush_dec),
        .freeze_all       (freeze),
        .mem_timeout      (tmo),
        .stall_cycles     (sc),
        .flush_count      (fc),
        .state_dbg        (st)
    );

    unidad_riesgos #(
        .ADDR_W      (AW),
        .CNT_W       (2),
        .MEM_TIMEOUT (TO)
    ) dut_sat (
        .clk              (clk),
        .rst              (rst),
        .src1_DEC         (src1),
        .src2_DEC         (src2),
        .src_used_DEC     (used),
        .dest_EXE         (dest),
        .MEM_R_EN_EXE     (ld),
        .branch_taken_EXE (br),
        .MEM_access_MEM   (macc),
        .mem_ready        (rdy),
        .clear_stats      (clr),
        .stall_PC         (s_stall_pc),
        .stall_DEC        (s_stall_dec),
        .bubble_EXE       (s_bubble),
        .flush_IF         (s_flush_if),
        .flush_DEC        (s_flush_dec),
        .freeze_all       (s_freeze),
        .mem_timeout      (s_tmo),
        .stall_cycles     (sc2),
        .flush_count      (fc2),
        .state_dbg        (s_st)
    );

    typedef struct packed {
        logic [5:0]  ctl;
        logic [19:0] regs;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int checks = 0;
    int errors = 0;

    // Reference state, always describing the registers after the last applied edge.
    bit m_st, m_to;
    int m_wcnt, m_sc, m_fc, m_sc2;

    logic [5:0]  obs_ctl;
    logic [19:0] obs_regs;
    assign obs_ctl  = {freeze, flush_if, flush_dec, stall_pc, stall_dec, bubble};
    assign obs_regs = {st, tmo, sc, fc, sc2};

    task automatic apply(input logic r, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                         input logic [1:0] u, input logic [AW-1:0] d, input logic l,
                         input logic b, input logic ma, input logic rd, input logic cl);
        logic       mw, lu;
        logic [5:0] c;
        exp_t       x;
        rst = r; src1 = s1; src2 = s2; used = u; dest = d;
        ld = l; br = b; macc = ma; rdy = rd; clr = cl;
        if (r) begin
            m_st = 0; m_to = 0; m_wcnt = 0; m_sc = 0; m_fc = 0; m_sc2 = 0;
        end
        mw = ma & ~rd;
        lu = l & ((u[0] & (s1 == d)) | (u[1] & (s2 == d)));
        c  = 6'b000000;
        if (!r) begin
            if (mw)      c = 6'b100000;
            else if (b)  c = 6'b011000;
            else if (lu) c = 6'b000111;
        end
        x.ctl  = c;
        x.regs = {m_st, m_to, 8'(m_sc), 8'(m_fc), 2'(m_sc2)};
        exp_q.push_back(x);
        if (!r) begin
            if (mw) begin
                m_wcnt = m_st ? ((m_wcnt < TO) ? m_wcnt + 1 : TO) : 1;
                m_st   = 1;
                if (m_wcnt == TO) m_to = 1;
            end else begin
                m_st   = 0;
                m_wcnt = 0;
            end
            if (cl) begin
                m_sc = 0; m_fc = 0; m_sc2 = 0;
            end else begin
                if (c[5] | c[2]) begin
                    if (m_sc < 255) m_sc++;
                    if (m_sc2 < 3) m_sc2++;
                end
                if (c[4] && m_fc < 255) m_fc++;
            end
        end
    endtask

    task automatic test_reset();
        apply(1, 5'd5, 5'd0, 2'b01, 5'd5, 1, 0, 0, 1, 0);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs_ctl !== e.ctl) begin
            errors++; $display("FAIL reset_ctl: got %b want %b", obs_ctl, e.ctl);
        end
        checks++;
        if (obs_regs !== e.regs) begin
            errors++; $display("FAIL reset_regs: got %h want %h", obs_regs, e.regs);
        end
        @(posedge clk); #1;
        apply(0, 5'd0, 5'd0, 2'b00, 5'd1, 0, 0, 0, 1, 0);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({obs_ctl, obs_regs} !== {e.ctl, e.regs}) begin
            errors++; $display("FAIL reset_idle: got %h want %h", {obs_ctl, obs_regs}, e);
        end
        @(posedge clk); #1;
    endtask

    // Load to r5 / unused-source / r0 match / idle, one row per cycle.
    task automatic test_load_use();
        logic [4:0] s1_t[6] = '{5, 0, 0, 0, 0, 3};
        logic [4:0] s2_t[6] = '{0, 0, 7, 7, 9, 0};
        logic [1:0] u_t[6]  = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b11, 2'b01};
        logic [4:0] d_t[6]  = '{5, 5, 5, 0, 9, 3};
        logic       l_t[6]  = '{1, 0, 1, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            apply(0, s1_t[i], s2_t[i], u_t[i], d_t[i], l_t[i], 0, 0, 1, 0);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs_ctl !== e.ctl) begin
                errors++; $display("FAIL load_use_ctl[%0d]: got %b want %b", i, obs_ctl, e.ctl);
            end
            checks++;
            if (obs_regs !== e.regs) begin
                errors++; $display("FAIL load_use_regs[%0d]: got %h want %h", i, obs_regs, e.regs);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 3; i++) begin
            apply(0, 5'd5, 5'd0, 2'b01, 5'd5, 1, (i == 0), 0, 1, 0);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({obs_ctl, obs_regs} !== {e.ctl, e.regs}) begin
                errors++;
                $display("FAIL branch[%0d]: got %h want %h", i, {obs_ctl, obs_regs}, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // Three waiting cycles then release; second pass holds a taken branch throughout.
    task automatic test_mem_wait();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 6; i++) begin
                apply(0, 5'd0, 5'd0, 2'b00, 5'd1, 0, (p == 1 && i < 4), (i < 4), (i >= 3), 0);
                @(negedge clk);
                e = exp_q.pop_front();
                checks++;
                if ({obs_ctl, obs_regs} !== {e.ctl, e.regs}) begin
                    errors++;
                    $display("FAIL mem_wait[%0d][%0d]: got %h want %h", p, i,
                             {obs_ctl, obs_regs}, e);
                end
                @(posedge clk); #1;
            end
        end
        // Ready in the same cycle as the access: no freeze, FSM stays in RUN.
        apply(0, 5'd0, 5'd0, 2'b00, 5'd1, 0, 0, 1, 1, 0);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({obs_ctl, obs_regs} !== {e.ctl, e.regs}) begin
            errors++; $display("FAIL mem_ready_same: got %h want %h", {obs_ctl, obs_regs}, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_watchdog();
        for (int i = 0; i < 11; i++) begin
            apply((i == 9), 5'd0, 5'd0, 2'b00, 5'd1, 0, 0, 1, (i >= 6), 0);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({obs_ctl, obs_regs} !== {e.ctl, e.regs}) begin
                errors++;
                $display("FAIL watchdog[%0d]: got %h want %h", i, {obs_ctl, obs_regs}, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) begin
            apply(0, 5'd2, 5'd0, 2'b01, 5'd2, (i != 7), 0, 0, 1, (i == 6));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({obs_ctl, obs_regs} !== {e.ctl, e.regs}) begin
                errors++;
                $display("FAIL saturation[%0d]: got %h want %h", i, {obs_ctl, obs_regs}, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            apply(0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 3) == 0),
                  1'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({obs_ctl, obs_regs} !== {e.ctl, e.regs}) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i, {obs_ctl, obs_regs}, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; src1 = '0; src2 = '0; used = '0; dest = '0;
        ld = 0; br = 0; macc = 0; rdy = 1; clr = 0;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_watchdog();
        test_saturation();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
